// File: rtl/rdc_seq.sv
// Burst sequencer: buffers one LANES-wide accumulator vector and streams each lane
// out, narrowed and saturated by a single shared reducer, one lane per beat.

package rdc_pkg;
    typedef struct packed {
        logic       sign;
        logic [7:0] prec;
    } dconf_t;
endpackage

`ifndef DEF_DCONF_INT
`define DEF_DCONF_INT '{sign: 1'b1, prec: 8'd32}
`endif
`ifndef DEF_DCONFS_INT
`define DEF_DCONFS_INT '{sign: 1'b1, prec: 8'd8}
`endif

module rdc_int #(
    parameter int I_PREC     = 32,
    parameter int O_PREC     = 8,
    parameter bit SIGNED_RDC = 1'b1
) (
    input  logic [I_PREC-1:0] in_val,
    output logic [O_PREC-1:0] out_val,
    output logic              ovf
);
    // Result packs {ovf, value}; saturation clamps toward the sign of the input.
    function automatic logic [O_PREC:0] sat_signed(input logic signed [I_PREC-1:0] x);
        logic s;
        s = x[I_PREC-1];
        if (x[I_PREC-2:O_PREC-1] != {(I_PREC-O_PREC){s}})
            return {1'b1, s, {(O_PREC-1){~s}}};
        return {1'b0, s, x[O_PREC-2:0]};
    endfunction

    function automatic logic [O_PREC:0] sat_unsigned(input logic [I_PREC-1:0] x);
        if (|x[I_PREC-1:O_PREC])
            return {1'b1, {O_PREC{1'b1}}};
        return {1'b0, x[O_PREC-1:0]};
    endfunction

    always_comb begin
        if (SIGNED_RDC)
            {ovf, out_val} = sat_signed(in_val);
        else
            {ovf, out_val} = sat_unsigned(in_val);
    end
endmodule

module rdc_seq #(
    parameter rdc_pkg::dconf_t I_CONF = `DEF_DCONF_INT,
    parameter rdc_pkg::dconf_t O_CONF = `DEF_DCONFS_INT,
    parameter int LANES     = 4,
    parameter int OVF_CNT_W = 16,
    parameter int I_PREC    = int'(I_CONF.prec),
    parameter int O_PREC    = int'(O_CONF.prec),
    parameter int LW        = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*I_PREC-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [O_PREC-1:0]       out_data,
    output logic                    out_ovf,
    output logic [LW-1:0]           out_lane,
    output logic                    out_last,
    output logic [OVF_CNT_W-1:0]    ovf_cnt,
    input  logic                    ovf_clr,
    output logic                    busy
);
    localparam logic [0:0]    S_IDLE    = 1'b0;
    localparam logic [0:0]    S_RUN     = 1'b1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [0:0]               state;
    logic [LANES*I_PREC-1:0]  lane_buf;
    logic [LW-1:0]            next_lane;
    logic [I_PREC-1:0]        rdc_in;
    logic [O_PREC-1:0]        rdc_out;
    logic                     rdc_ovf;
    logic                     accept;
    logic                     ovf_hit;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_RUN);
    assign accept    = (state == S_RUN) && out_ready;
    assign ovf_hit   = accept && out_ovf;

    // In IDLE the reducer sees lane 0 straight from the input so it lands with the capture.
    always_comb begin
        next_lane = (out_lane == LAST_LANE) ? '0 : out_lane + LW'(1);
        if (state == S_IDLE)
            rdc_in = in_data[I_PREC-1:0];
        else
            rdc_in = lane_buf[int'(next_lane)*I_PREC +: I_PREC];
    end

    rdc_int #(
        .I_PREC     (I_PREC),
        .O_PREC     (O_PREC),
        .SIGNED_RDC (I_CONF.sign)
    ) u_rdc (
        .in_val  (rdc_in),
        .out_val (rdc_out),
        .ovf     (rdc_ovf)
    );

    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid)
            lane_buf <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_lane <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state    <= S_RUN;
                        out_data <= rdc_out;
                        out_ovf  <= rdc_ovf;
                        out_lane <= '0;
                        out_last <= 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state <= S_IDLE;
                        end else begin
                            out_data <= rdc_out;
                            out_ovf  <= rdc_ovf;
                            out_lane <= next_lane;
                            out_last <= (next_lane == LAST_LANE);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf_cnt <= '0;
        else if (ovf_clr)
            ovf_cnt <= ovf_hit ? OVF_CNT_W'(1) : '0;
        else if (ovf_hit && !(&ovf_cnt))
            ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
endmodule
